backprop_collector: RTL and testbench
=====================================

BACKPROP_COLLECTOR -- requirements
Module: backprop_collector

Interface
REQ-001 SHALL have parameter LANES, default 32, giving the lane count; it matches the per-neuron dendrite count.
REQ-002 SHALL have parameter AVERAGE, default 0; 0 = emit lane sums, 1 = emit lane sums divided by contribution count.
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 bc_clock  input  1  sole clock; all state updates on posedge.
REQ-005 bc_reset  input  1  synchronous active-high reset.
REQ-006 bc_num_sources  input  6  number of downstream neurons contributing per round; 0 treated as 1, values >32 treated as 32.
REQ-007 bc_in_valid  input  1  a contribution vector is present.
REQ-008 bc_in_ready  output  1  collector accepts a contribution this cycle.
REQ-009 bc_in_changes  input  real[LANES-1:0]  one downstream neuron's per-dendrite backprop change vector.
REQ-010 bc_in_enabled  input  LANES  lane mask; a cleared bit contributes 0.0 on that lane.
REQ-011 bc_flush  input  1  emit a partial round early.
REQ-012 bc_out_valid  output  1  the aggregated error vector is valid.
REQ-013 bc_out_ready  input  1  the consumer takes the vector.
REQ-014 bc_out_backprop  output  real[LANES-1:0]  aggregated error per lane; it feeds each upstream neuron's backprop input.
REQ-015 bc_out_count  output  6  number of contributions folded into bc_out_backprop.

Function
REQ-016 SHALL implement states ACCUM and HOLD; bc_in_ready = 1 only in ACCUM, and bc_out_valid = 1 only in HOLD.
REQ-017 Accept = bc_in_valid & bc_in_ready; on accept, each lane acc[i] += bc_in_enabled[i] ? bc_in_changes[i] : 0.0, and count += 1.
REQ-018 The target N SHALL be latched from bc_num_sources on the first accept of a round; changes to bc_num_sources mid-round are ignored.
REQ-019 When an accept makes count == N, the FSM SHALL go to HOLD on the next posedge; bc_out_valid rises in the cycle after the final accepted beat (1-cycle latency).
REQ-020 bc_flush asserted in ACCUM with count > 0 SHALL move the FSM to HOLD next cycle using the current count.
REQ-021 bc_flush with count == 0 and no accept SHALL be ignored.
REQ-022 If accept and bc_flush occur in the same cycle, the beat SHALL be accumulated first, then the round is emitted including it.
REQ-023 In HOLD, bc_out_backprop and bc_out_count SHALL stay stable until bc_out_valid & bc_out_ready.
REQ-024 On that handshake, the block SHALL clear all accumulators and count to 0.0 / 0 and return to ACCUM; no input is accepted in that same cycle.
REQ-025 AVERAGE=1: bc_out_backprop[i] = acc[i] / real'(count); AVERAGE=0: bc_out_backprop[i] = acc[i].
REQ-026 bc_in_valid asserted while in HOLD SHALL cause no state change; the source holds its data (valid/ready rule).
REQ-027 count SHALL never exceed 32 and never wrap; N=32 is the maximum round.

Reset
REQ-028 While bc_reset = 1 at posedge: state = ACCUM, count = 0, N = 1, all accumulators = 0.0, bc_out_valid = 0, bc_out_count = 0, bc_out_backprop = 0.0 on all lanes, bc_in_ready = 1 after release.
REQ-029 Reset mid-round or in HOLD SHALL discard partial sums and any pending output with no emission.

Verification
REQ-030 N=3, three beats of lane0 = 0.5, 0.25, -0.125, all lanes enabled, AVERAGE=0 -> out_valid one cycle after beat 3; lane0 = 0.625; count = 3.
REQ-031 Same stimulus with AVERAGE=1 -> lane0 = 0.208333 (±1e-9); count = 3.
REQ-032 N=4, bc_in_enabled = 0xFFFFFFFE, lane0 = 1.0 every beat -> lane0 = 0.0; lane1 = sum of its inputs.
REQ-033 N=4, two beats accepted, then bc_flush asserted together with a third beat -> count = 3; sums include the third beat.
REQ-034 Hold bc_out_ready = 0 for 5 cycles while bc_in_valid = 1 -> in_ready stays 0, outputs stable, no beat lost; after the handshake, the next beat starts a fresh round with count = 1.
REQ-035 Assert bc_reset after 2 of 3 beats -> no out_valid appears; the next 3 beats produce sums of only those 3 beats.

Source files
------------

// File: rtl/backprop_collector.sv
// Collects per-neuron backprop change vectors across a round of downstream
// contributions and presents the lane-wise sum (or average) for upstream neurons.
module backprop_collector #(
  parameter int LANES   = 32,
  parameter int AVERAGE = 0
) (
  input  logic             bc_clock,
  input  logic             bc_reset,
  input  logic [5:0]       bc_num_sources,
  input  logic             bc_in_valid,
  output logic             bc_in_ready,
  input  real              bc_in_changes [LANES-1:0],
  input  logic [LANES-1:0] bc_in_enabled,
  input  logic             bc_flush,
  output logic             bc_out_valid,
  input  logic             bc_out_ready,
  output real              bc_out_backprop [LANES-1:0],
  output logic [5:0]       bc_out_count,
  output logic             bc_dbg_state
);

  // Handshake rule on both ports: a transfer happens on a posedge where valid and
  // ready are both high; a producer holds valid and data stable until it happens.
  typedef enum logic {ACCUM = 1'b0, HOLD = 1'b1} state_t;

  state_t     state_q, state_d;
  logic [5:0] count_q, count_d;
  logic [5:0] target_q, target_d;
  real        acc_q [LANES-1:0];
  real        acc_d [LANES-1:0];

  logic       accept;
  logic [5:0] n_clamped;
  logic [5:0] n_eff;

  always_comb begin
    n_clamped = bc_num_sources;
    if (bc_num_sources == 6'd0) begin
      n_clamped = 6'd1;
    end else if (bc_num_sources > 6'd32) begin
      n_clamped = 6'd32;
    end
  end

  // The round target is latched on its first beat, so that beat must use the live value.
  assign n_eff  = (count_q == 6'd0) ? n_clamped : target_q;
  assign accept = bc_in_valid && (state_q == ACCUM);

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    target_d = target_q;
    for (int i = 0; i < LANES; i++) begin
      acc_d[i] = acc_q[i];
    end

    case (state_q)
      ACCUM: begin
        if (accept) begin
          for (int i = 0; i < LANES; i++) begin
            acc_d[i] = acc_q[i] + (bc_in_enabled[i] ? bc_in_changes[i] : 0.0);
          end
          count_d = count_q + 6'd1;
          if (count_q == 6'd0) begin
            target_d = n_clamped;
          end
        end
        // A flush that coincides with a beat emits the round including that beat.
        if ((accept && (count_d == n_eff)) || (bc_flush && (count_d != 6'd0))) begin
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (bc_out_ready) begin
          state_d = ACCUM;
          count_d = 6'd0;
          for (int i = 0; i < LANES; i++) begin
            acc_d[i] = 0.0;
          end
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge bc_clock) begin
    if (bc_reset) begin
      state_q  <= ACCUM;
      count_q  <= 6'd0;
      target_q <= 6'd1;
      for (int i = 0; i < LANES; i++) begin
        acc_q[i] <= 0.0;
      end
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      target_q <= target_d;
      for (int i = 0; i < LANES; i++) begin
        acc_q[i] <= acc_d[i];
      end
    end
  end

  assign bc_in_ready  = (state_q == ACCUM);
  assign bc_out_valid = (state_q == HOLD);
  assign bc_out_count = count_q;
  assign bc_dbg_state = state_q;

  // Accumulators are frozen in HOLD, so the presented vector is stable until taken.
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      if (AVERAGE != 0) begin
        bc_out_backprop[i] = (count_q != 6'd0) ? acc_q[i] / real'(count_q) : 0.0;
      end else begin
        bc_out_backprop[i] = acc_q[i];
      end
    end
  end

endmodule

// File: tb/tb_backprop_collector.sv
// Directed bench for backprop_collector: a sum instance and an average instance
// share stimulus; expected rounds are queued as beats are driven.
module tb_backprop_collector;

  localparam int LANES = 32;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [5:0]       num_sources = 6'd1;
  logic             in_valid = 1'b0;
  real              in_changes [LANES-1:0];
  logic [LANES-1:0] in_enabled = '1;
  logic             flush = 1'b0;
  logic             out_ready = 1'b0;

  logic             in_ready_s, out_valid_s, dbg_s;
  logic             in_ready_a, out_valid_a, dbg_a;
  real              out_bp_s [LANES-1:0];
  real              out_bp_a [LANES-1:0];
  logic [5:0]       out_cnt_s, out_cnt_a;

  backprop_collector #(.LANES(LANES), .AVERAGE(0)) dut_sum (
    .bc_clock(clk), .bc_reset(rst), .bc_num_sources(num_sources),
    .bc_in_valid(in_valid), .bc_in_ready(in_ready_s), .bc_in_changes(in_changes),
    .bc_in_enabled(in_enabled), .bc_flush(flush), .bc_out_valid(out_valid_s),
    .bc_out_ready(out_ready), .bc_out_backprop(out_bp_s), .bc_out_count(out_cnt_s),
    .bc_dbg_state(dbg_s)
  );

  backprop_collector #(.LANES(LANES), .AVERAGE(1)) dut_avg (
    .bc_clock(clk), .bc_reset(rst), .bc_num_sources(num_sources),
    .bc_in_valid(in_valid), .bc_in_ready(in_ready_a), .bc_in_changes(in_changes),
    .bc_in_enabled(in_enabled), .bc_flush(flush), .bc_out_valid(out_valid_a),
    .bc_out_ready(out_ready), .bc_out_backprop(out_bp_a), .bc_out_count(out_cnt_a),
    .bc_dbg_state(dbg_a)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Scoreboard: one entry per expected emitted round.
  real        exp_l0_q[$];
  real        exp_l1_q[$];
  logic [5:0] exp_cnt_q[$];

  real        m_l0, m_l1;
  logic [5:0] m_cnt;

  function automatic real rabs(input real x);
    return (x < 0.0) ? -x : x;
  endfunction

  task automatic check_bits(input string tag, input logic [5:0] got, input logic [5:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic check_real(input string tag, input real got, input real exp);
    tests++;
    assert (rabs(got - exp) <= 1.0e-9) else begin
      fails++;
      $error("FAIL %s got=%f exp=%f", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    m_l0 = 0.0; m_l1 = 0.0; m_cnt = 6'd0;
  endtask

  task automatic model_add(input real l0, input real l1, input logic [LANES-1:0] en);
    m_l0 = m_l0 + (en[0] ? l0 : 0.0);
    m_l1 = m_l1 + (en[1] ? l1 : 0.0);
    m_cnt = m_cnt + 6'd1;
  endtask

  task automatic push_round();
    exp_l0_q.push_back(m_l0);
    exp_l1_q.push_back(m_l1);
    exp_cnt_q.push_back(m_cnt);
    model_clear();
  endtask

  task automatic set_beat(input real l0, input real l1, input logic [LANES-1:0] en);
    for (int i = 0; i < LANES; i++) in_changes[i] = 0.0;
    in_changes[0] = l0;
    in_changes[1] = l1;
    in_enabled = en;
  endtask

  // Called #1 after a posedge; returns #1 after the posedge that accepted the beat.
  task automatic send_beat(input real l0, input real l1, input logic [LANES-1:0] en,
                           input logic fl);
    int waited = 0;
    set_beat(l0, l1, en);
    in_valid = 1'b1;
    flush = fl;
    while (!in_ready_s && waited < 50) begin
      @(posedge clk); #1;
      waited++;
    end
    check_bits("beat_ready", {5'd0, in_ready_s}, 6'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    flush = 1'b0;
    model_add(l0, l1, en);
  endtask

  task automatic check_out(input string tag);
    int waited = 0;
    real e0, e1;
    logic [5:0] ec;
    while (!out_valid_s && waited < 50) begin
      @(posedge clk); #1;
      waited++;
    end
    check_bits({tag, "_valid_sum"}, {5'd0, out_valid_s}, 6'd1);
    check_bits({tag, "_valid_avg"}, {5'd0, out_valid_a}, 6'd1);
    if (exp_cnt_q.size() == 0) begin
      tests++; fails++;
      $error("FAIL %s_scoreboard got=empty exp=entry", tag);
    end else begin
      e0 = exp_l0_q.pop_front();
      e1 = exp_l1_q.pop_front();
      ec = exp_cnt_q.pop_front();
      check_bits({tag, "_count"}, out_cnt_s, ec);
      check_bits({tag, "_count_avg"}, out_cnt_a, ec);
      check_real({tag, "_lane0"}, out_bp_s[0], e0);
      check_real({tag, "_lane1"}, out_bp_s[1], e1);
      check_real({tag, "_lane0_avg"}, out_bp_a[0], e0 / real'(ec));
      check_real({tag, "_lane1_avg"}, out_bp_a[1], e1 / real'(ec));
    end
  endtask

  task automatic handshake(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check_bits({tag, "_hs_valid"}, {5'd0, out_valid_s}, 6'd0);
    check_bits({tag, "_hs_count"}, out_cnt_s, 6'd0);
    check_bits({tag, "_hs_ready"}, {5'd0, in_ready_s}, 6'd1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_clear();
  endtask

  real v;
  real held_l0;

  initial begin
    for (int i = 0; i < LANES; i++) in_changes[i] = 0.0;
    model_clear();
    @(posedge clk); #1;
    do_reset();

    // Reset state
    check_bits("rst_out_valid", {5'd0, out_valid_s}, 6'd0);
    check_bits("rst_count", out_cnt_s, 6'd0);
    check_bits("rst_in_ready", {5'd0, in_ready_s}, 6'd1);
    check_real("rst_lane0", out_bp_s[0], 0.0);
    check_real("rst_lane31", out_bp_s[31], 0.0);

    // Three-beat round; a mid-round change of num_sources must be ignored
    num_sources = 6'd3;
    send_beat(0.5, 1.0, '1, 1'b0);
    num_sources = 6'd5;
    send_beat(0.25, 2.0, '1, 1'b0);
    send_beat(-0.125, 3.0, '1, 1'b0);
    check_bits("n3_latency", {5'd0, out_valid_s}, 6'd1);
    check_real("n3_lane0_const", out_bp_s[0], 0.625);
    check_real("n3_avg_const", out_bp_a[0], 0.625 / 3.0);
    push_round();
    check_out("n3");
    handshake("n3");

    // Lane 0 masked off for a whole round
    num_sources = 6'd4;
    for (int k = 0; k < 4; k++) begin
      v = real'($urandom_range(0, 16)) / 4.0 - 2.0;
      send_beat(1.0, v, 32'hFFFF_FFFE, 1'b0);
    end
    check_real("mask_lane0_const", out_bp_s[0], 0.0);
    push_round();
    check_out("mask");
    handshake("mask");

    // Flush together with the third beat of a four-beat round
    num_sources = 6'd4;
    send_beat(1.5, -0.5, '1, 1'b0);
    send_beat(0.25, 0.75, '1, 1'b0);
    send_beat(-1.0, 4.0, '1, 1'b1);
    check_bits("flush_latency", {5'd0, out_valid_s}, 6'd1);
    push_round();
    check_out("flush");
    handshake("flush");

    // Backpressure: consumer stalls while a new beat is waiting
    num_sources = 6'd2;
    send_beat(0.5, 0.5, '1, 1'b0);
    send_beat(0.125, -0.25, '1, 1'b0);
    push_round();
    num_sources = 6'd1;
    set_beat(0.75, 0.5, '1);
    in_valid = 1'b1;
    held_l0 = exp_l0_q[0];
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      check_bits("stall_in_ready", {5'd0, in_ready_s}, 6'd0);
      check_bits("stall_count", out_cnt_s, 6'd2);
      check_real("stall_lane0", out_bp_s[0], held_l0);
    end
    check_out("stall");
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check_bits("stall_hs_count", out_cnt_s, 6'd0);
    check_bits("stall_hs_valid", {5'd0, out_valid_s}, 6'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    model_add(0.75, 0.5, '1);
    push_round();
    check_out("fresh");
    handshake("fresh");

    // Flush on an empty round is ignored
    flush = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    flush = 1'b0;
    check_bits("empty_flush_valid", {5'd0, out_valid_s}, 6'd0);
    check_bits("empty_flush_count", out_cnt_s, 6'd0);

    // num_sources of 0 behaves as 1
    num_sources = 6'd0;
    send_beat(-0.75, 1.25, '1, 1'b0);
    push_round();
    check_out("n0");
    handshake("n0");

    // Reset mid-round discards the partial sums
    num_sources = 6'd3;
    send_beat(8.0, 8.0, '1, 1'b0);
    send_beat(4.0, 4.0, '1, 1'b0);
    do_reset();
    for (int k = 0; k < 3; k++) begin
      check_bits("rst_mid_valid", {5'd0, out_valid_s}, 6'd0);
      @(posedge clk); #1;
    end
    check_bits("rst_mid_count", out_cnt_s, 6'd0);
    num_sources = 6'd3;
    send_beat(0.25, 1.0, '1, 1'b0);
    send_beat(0.5, -1.0, '1, 1'b0);
    send_beat(0.75, 0.5, '1, 1'b0);
    push_round();
    check_out("post_rst");
    handshake("post_rst");

    // Oversized num_sources clamps to a 32-beat round
    num_sources = 6'd40;
    for (int k = 0; k < 32; k++) begin
      v = real'($urandom_range(0, 8)) / 8.0;
      send_beat(v, 0.5, '1, 1'b0);
      if (k == 30) check_bits("clamp_not_early", {5'd0, out_valid_s}, 6'd0);
    end
    push_round();
    check_out("clamp32");
    handshake("clamp32");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
